// File: rtl/riscv_lsu.sv
// Load/store unit: turns CPU load/store requests into req/ack word-bus transactions.
// Optional misaligned-access trapping is enabled by defining RISCV_MISALIGN_TRAP_EN.
module riscv_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [2:0]  cpu_funct3,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_we,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Access size: 0 byte, 1 halfword, 2 word (reserved encodings behave as word)
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      logic [1:0] sz;
      case (f3)
         3'b000, 3'b100: sz = 2'd0;
         3'b001, 3'b101: sz = 2'd1;
         default:        sz = 2'd2;
      endcase
      return sz;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be;
      case (size_of(f3))
         2'd0:    be = 4'b0001 << a;
         2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] d;
      case (size_of(f3))
         2'd0:    d = {4{wd[7:0]}};
         2'd1:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{a, 3'b000} +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic [31:0] tcnt_q, tcnt_d;
   logic        stall_s;
   logic [1:0]  off_s;

   // Byte offset after alignment; misaligned halfword/word accesses round down
   always_comb begin
      case (size_of(cpu_funct3))
         2'd0:    off_s = cpu_addr[1:0];
         2'd1:    off_s = {cpu_addr[1], 1'b0};
         default: off_s = 2'b00;
      endcase
   end

   // Next-state, bus-register and stall logic
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      off_d    = off_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      req_d    = req_q;
      rdata_d  = rdata_q;
      fault_d  = 1'b0;
      tcnt_d   = tcnt_q;
      stall_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_s = cpu_read | cpu_write;
            tcnt_d  = 32'd0;
            if (cpu_read || cpu_write) begin
               funct3_d = cpu_funct3;
               off_d    = off_s;
               addr_d   = {cpu_addr[31:2], 2'b00};
               we_d     = cpu_write;
               be_d     = cpu_write ? store_be(cpu_funct3, off_s) : 4'b1111;
               wdata_d  = store_data(cpu_funct3, cpu_wdata);
`ifdef RISCV_MISALIGN_TRAP_EN
               if ((size_of(cpu_funct3) == 2'd1 && cpu_addr[0]) ||
                   (size_of(cpu_funct3) == 2'd2 && cpu_addr[1:0] != 2'b00)) begin
                  state_d = S_DONE;
                  fault_d = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
               end
`else
               state_d = S_REQ;
               req_d   = 1'b1;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            stall_s = 1'b1;
            if (mem_ack) begin
               rdata_d = we_q ? 32'd0 : load_extend(funct3_q, off_q, mem_rdata);
               req_d   = 1'b0;
               tcnt_d  = 32'd0;
               state_d = S_DONE;
            end else if (TIMEOUT_CYCLES != 32'd0 && tcnt_q + 32'd1 == TIMEOUT_CYCLES) begin
               rdata_d = 32'd0;
               req_d   = 1'b0;
               tcnt_d  = 32'd0;
               state_d = S_DONE;
`ifdef RISCV_MISALIGN_TRAP_EN
               fault_d = 1'b1;
`else
               fault_d = 1'b0;
`endif
            end else begin
               tcnt_d = (TIMEOUT_CYCLES != 32'd0) ? tcnt_q + 32'd1 : 32'd0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and registered bus outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         addr_q   <= 32'd0;
         off_q    <= 2'd0;
         funct3_q <= 3'd0;
         we_q     <= 1'b0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         req_q    <= 1'b0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
         tcnt_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         off_q    <= off_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         req_q    <= req_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign cpu_stall = reset_n ? stall_s : 1'b0;
   assign cpu_rdata = rdata_q;
   assign fault     = fault_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign mem_we    = we_q;
   assign mem_req   = req_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (TIMEOUT_CYCLES=8).
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_read, cpu_write, cpu_stall, fault;
   logic [2:0]  cpu_funct3;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_we, mem_req, mem_ack;

   int tests_run = 0;
   int fails = 0;

   logic [31:0] o_addr, o_wdata, o_rdata;
   logic [3:0]  o_be;
   logic        o_we, o_fault, o_done, o_stall_first, o_stable, o_req_in_done;
   int          o_req_cycles, o_done_cycle;

   riscv_lsu #(.TIMEOUT_CYCLES(32'd8)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .fault(fault),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Drives one request, acks after ack_delay REQ cycles (negative: never), records what was seen
   task automatic run_txn(input logic wr, input logic rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_delay, input logic [31:0] rdat);
      @(posedge clk); #1;
      cpu_write = wr; cpu_read = rd; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
      mem_ack = 1'b0;
      o_done = 1'b0; o_stable = 1'b1; o_req_cycles = 0; o_done_cycle = 0;
      o_addr = 32'hX; o_wdata = 32'hX; o_be = 4'hX; o_we = 1'bX;
      o_rdata = 32'hX; o_fault = 1'bX; o_req_in_done = 1'bX;
      #1 o_stall_first = cpu_stall;
      for (int i = 1; i <= 300 && !o_done; i++) begin
         @(posedge clk); #1;
         if (!cpu_stall) begin
            o_done = 1'b1; o_done_cycle = i + 1;
            o_rdata = cpu_rdata; o_fault = fault; o_req_in_done = mem_req;
            mem_ack = 1'b0;
         end else if (mem_req) begin
            if (o_req_cycles == 0) begin
               o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
            end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                         mem_be !== o_be || mem_we !== o_we) begin
               o_stable = 1'b0;
            end
            if (o_req_cycles == ack_delay) begin
               mem_ack = 1'b1; mem_rdata = rdat;
            end else begin
               mem_ack = 1'b0; mem_rdata = 32'hDEADDEAD;
            end
            o_req_cycles++;
         end
      end
      cpu_write = 1'b0; cpu_read = 1'b0; mem_ack = 1'b0;
      tests_run++;
      if (!o_done) begin
         $display("FAIL txn_done: no DONE within budget, got stall=%b required DONE", cpu_stall);
         fails++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cpu_read = 1'b1; cpu_write = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (cpu_stall !== 1'b0) begin $display("FAIL rst_stall: got %b required 0", cpu_stall); fails++; end
      tests_run++; if (mem_req !== 1'b0) begin $display("FAIL rst_req: got %b required 0", mem_req); fails++; end
      tests_run++; if (mem_we !== 1'b0 || mem_be !== 4'd0) begin $display("FAIL rst_we_be: got %b/%b required 0/0000", mem_we, mem_be); fails++; end
      tests_run++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin $display("FAIL rst_bus: got %h/%h required 0/0", mem_addr, mem_wdata); fails++; end
      tests_run++; if (cpu_rdata !== 32'd0 || fault !== 1'b0) begin $display("FAIL rst_rdata_fault: got %h/%b required 0/0", cpu_rdata, fault); fails++; end
      cpu_read = 1'b0; cpu_write = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
   endtask

   task automatic test_stores();
      run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'hCAFEBABE, 0, 32'd0);
      tests_run++; if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b1) begin $display("FAIL sw_bus: got addr=%h be=%b we=%b required 100/1111/1", o_addr, o_be, o_we); fails++; end
      tests_run++; if (o_wdata !== 32'hCAFEBABE) begin $display("FAIL sw_wdata: got %h required cafebabe", o_wdata); fails++; end
      tests_run++; if (o_stall_first !== 1'b1 || o_done_cycle != 3) begin $display("FAIL sw_latency: got stall0=%b done_cycle=%0d required 1/3", o_stall_first, o_done_cycle); fails++; end
      run_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'h000000A5, 0, 32'd0);
      tests_run++; if (o_addr !== 32'h200 || o_be !== 4'b1000 || o_wdata !== 32'hA5A5A5A5) begin $display("FAIL sb_lane: got %h/%b/%h required 200/1000/a5a5a5a5", o_addr, o_be, o_wdata); fails++; end
      run_txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h1234BEEF, 1, 32'd0);
      tests_run++; if (o_addr !== 32'h100 || o_be !== 4'b1100 || o_wdata !== 32'hBEEFBEEF) begin $display("FAIL sh_lane: got %h/%b/%h required 100/1100/beefbeef", o_addr, o_be, o_wdata); fails++; end
      run_txn(1'b1, 1'b1, 3'b111, 32'h900, 32'h0BADF00D, 0, 32'd0);
      tests_run++; if (o_we !== 1'b1 || o_be !== 4'b1111 || o_wdata !== 32'h0BADF00D) begin $display("FAIL write_wins: got we=%b be=%b wd=%h required 1/1111/0badf00d", o_we, o_be, o_wdata); fails++; end
   endtask

   task automatic test_loads();
      run_txn(1'b0, 1'b1, 3'b000, 32'h301, 32'd0, 4, 32'h1234F0AB);
      tests_run++; if (o_rdata !== 32'hFFFFFFF0) begin $display("FAIL lb_rdata: got %h required fffffff0", o_rdata); fails++; end
      tests_run++; if (o_req_cycles != 5 || o_stable !== 1'b1) begin $display("FAIL lb_wait: got req_cycles=%0d stable=%b required 5/1", o_req_cycles, o_stable); fails++; end
      tests_run++; if (o_addr !== 32'h300 || o_be !== 4'b1111 || o_we !== 1'b0) begin $display("FAIL lb_bus: got %h/%b/%b required 300/1111/0", o_addr, o_be, o_we); fails++; end
      run_txn(1'b0, 1'b1, 3'b100, 32'h301, 32'd0, 4, 32'h1234F0AB);
      tests_run++; if (o_rdata !== 32'h000000F0) begin $display("FAIL lbu_rdata: got %h required 000000f0", o_rdata); fails++; end
      run_txn(1'b0, 1'b1, 3'b001, 32'h402, 32'd0, 0, 32'h80010000);
      tests_run++; if (o_rdata !== 32'hFFFF8001) begin $display("FAIL lh_rdata: got %h required ffff8001", o_rdata); fails++; end
      run_txn(1'b0, 1'b1, 3'b101, 32'h402, 32'd0, 0, 32'h80010000);
      tests_run++; if (o_rdata !== 32'h00008001) begin $display("FAIL lhu_rdata: got %h required 00008001", o_rdata); fails++; end
      run_txn(1'b0, 1'b1, 3'b011, 32'h600, 32'd0, 2, 32'h89ABCDEF);
      tests_run++; if (o_rdata !== 32'h89ABCDEF) begin $display("FAIL lw011_rdata: got %h required 89abcdef", o_rdata); fails++; end
   endtask

   task automatic test_misaligned();
      run_txn(1'b0, 1'b1, 3'b001, 32'h402, 32'd0, 0, 32'h80010000);
      run_txn(1'b0, 1'b1, 3'b001, 32'h403, 32'd0, 0, 32'h80010000);
`ifdef RISCV_MISALIGN_TRAP_EN
      tests_run++; if (o_req_cycles != 0 || o_done_cycle != 2) begin $display("FAIL mis_noreq: got req_cycles=%0d done_cycle=%0d required 0/2", o_req_cycles, o_done_cycle); fails++; end
      tests_run++; if (o_fault !== 1'b1 || o_rdata !== 32'd0) begin $display("FAIL mis_fault: got fault=%b rdata=%h required 1/0", o_fault, o_rdata); fails++; end
`else
      tests_run++; if (o_addr !== 32'h400 || o_rdata !== 32'hFFFF8001) begin $display("FAIL mis_align: got %h/%h required 400/ffff8001", o_addr, o_rdata); fails++; end
      tests_run++; if (o_fault !== 1'b0) begin $display("FAIL mis_fault: got %b required 0", o_fault); fails++; end
`endif
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 1'b1, 3'b010, 32'hA00, 32'd0, -1, 32'd0);
      tests_run++; if (o_req_cycles != 8 || o_done_cycle != 10) begin $display("FAIL to_cycles: got req=%0d done=%0d required 8/10", o_req_cycles, o_done_cycle); fails++; end
      tests_run++; if (o_rdata !== 32'd0 || o_req_in_done !== 1'b0) begin $display("FAIL to_done: got rdata=%h req=%b required 0/0", o_rdata, o_req_in_done); fails++; end
`ifdef RISCV_MISALIGN_TRAP_EN
      tests_run++; if (o_fault !== 1'b1) begin $display("FAIL to_fault: got %b required 1", o_fault); fails++; end
`else
      tests_run++; if (o_fault !== 1'b0) begin $display("FAIL to_fault: got %b required 0", o_fault); fails++; end
`endif
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      cpu_write = 1'b1; cpu_read = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h800; cpu_wdata = 32'h01020304;
      @(posedge clk); #1 mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      tests_run++; if (cpu_stall !== 1'b0) begin $display("FAIL b2b_done1: got stall=%b required 0", cpu_stall); fails++; end
      cpu_addr = 32'h804; cpu_wdata = 32'h05060708;
      @(posedge clk); #1;
      tests_run++; if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin $display("FAIL b2b_idle: got stall=%b req=%b required 1/0", cpu_stall, mem_req); fails++; end
      @(posedge clk); #1;
      tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h804 || mem_wdata !== 32'h05060708) begin $display("FAIL b2b_req2: got req=%b %h/%h required 1/804/05060708", mem_req, mem_addr, mem_wdata); fails++; end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      tests_run++; if (cpu_stall !== 1'b0) begin $display("FAIL b2b_done2: got stall=%b required 0", cpu_stall); fails++; end
      cpu_write = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      cpu_read = 1'b1; cpu_write = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h700;
      @(posedge clk); #1;
      tests_run++; if (mem_req !== 1'b1) begin $display("FAIL rm_req: got %b required 1", mem_req); fails++; end
      reset_n = 1'b0;
      #1;
      tests_run++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin $display("FAIL rm_drop: got req=%b stall=%b required 0/0", mem_req, cpu_stall); fails++; end
      cpu_read = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      tests_run++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'd0) begin $display("FAIL rm_ack_ignored: got req=%b stall=%b rdata=%h required 0/0/0", mem_req, cpu_stall, cpu_rdata); fails++; end
      run_txn(1'b0, 1'b1, 3'b010, 32'h704, 32'd0, 0, 32'h2468ACE0);
      tests_run++; if (o_rdata !== 32'h2468ACE0 || o_addr !== 32'h704 || o_done_cycle != 3) begin $display("FAIL rm_next: got %h/%h/%0d required 2468ace0/704/3", o_rdata, o_addr, o_done_cycle); fails++; end
   endtask

   initial begin
      reset_n = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_read = 1'b0; cpu_write = 1'b0;
      cpu_funct3 = 3'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      test_reset();
      test_stores();
      test_loads();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of riscv_cpu's data_memory_* port.
- Turns the CPU's single-cycle load/store request into a multi-cycle req/ack transaction on a word-wide, byte-enabled memory bus.
- Stalls the CPU until the access completes.
- Performs byte/halfword lane steering on stores and sign/zero extension on loads, per funct3.

Parameters:
- TIMEOUT_CYCLES, 255: REQ-state cycles without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  32  byte address (ALU result)
- cpu_wdata  in  32  store data, rs2, right-aligned
- cpu_read  in  1  load request, level, held while cpu_stall=1
- cpu_write  in  1  store request, level, held while cpu_stall=1
- cpu_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- cpu_rdata  out  32  extended load result, valid while state=DONE
- cpu_stall  out  1  CPU must hold PC and request inputs
- fault  out  1  misaligned/timeout flag, valid in DONE
- mem_addr  out  32  word address, bits[1:0]=00
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, bit n = byte lane n
- mem_we  out  1  1 = write
- mem_req  out  1  request, held until ack
- mem_ack  in  1  one-cycle completion strobe
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, cpu_rdata, fault and the timeout counter all 0.
  - cpu_stall forced 0 while reset_n is low.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - cpu_stall = cpu_read|cpu_write (combinational).
  - On a request, latch addr, funct3, wdata and direction; go to REQ.
  - If cpu_read and cpu_write are both high, the write wins.
  - mem_ack is ignored in IDLE.
- REQ:
  - mem_req=1 and cpu_stall=1.
  - Bus outputs are registered and stable for the whole state.
  - mem_ack=1: capture mem_rdata, go to DONE.
  - Timeout counter increments each REQ cycle. When it reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to DONE with cpu_rdata=0.
- DONE:
  - Lasts exactly 1 cycle; cpu_stall=0 and the CPU commits.
  - Next state is IDLE unconditionally, so back-to-back requests are re-sampled one cycle later.
- Latency: minimum 3 cycles, request to DONE, when mem_ack arrives in the first REQ cycle.
- Store lanes, with a = cpu_addr[1:0]:
  - SB: be = 0001 << a; wdata = byte replicated x4.
  - SH: be = a[1] ? 1100 : 0011; wdata = halfword replicated x2.
  - SW: be = 1111.
- Loads:
  - mem_be=1111 and mem_we=0.
  - The byte or halfword lane is selected by the latched addr bits.
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
- funct3 011, 110 and 111 are treated as W.
- Misaligned access = H/HU with a[0]=1, or W with a!=00. Handling depends on RISCV_MISALIGN_TRAP_EN.
- Reset asserted mid-transaction: immediate return to IDLE and mem_req drops. No ack is expected or consumed afterwards.

Optional Feature:
- Macro: RISCV_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no bus request; IDLE goes straight to DONE.
  - DONE then has fault=1 and cpu_rdata=0.
  - A timeout also sets fault=1 in DONE.
- Undefined:
  - A misaligned address is aligned down (H: bit0 cleared; W: bits[1:0] cleared) and the access proceeds normally.
  - fault is tied to 0.

Test Plan:
- SW addr=0x100, wdata=0xCAFEBABE, ack in the first REQ cycle:
  - mem_addr=0x100, be=1111, we=1.
  - cpu_stall high 2 cycles; DONE on cycle 3.
- SB addr=0x203, wdata=0x000000A5:
  - mem_addr=0x200, be=1000, mem_wdata=0xA5A5A5A5.
- LB and LBU at addr=0x301, mem_rdata=0x1234F0AB, ack after 4 wait cycles:
  - LB gives cpu_rdata=0xFFFFFFF0; LBU gives 0x000000F0.
  - Stall is held through the waits.
- LH addr=0x402, mem_rdata=0x80010000:
  - cpu_rdata=0xFFFF8001.
  - LH addr=0x403 with the macro defined: no mem_req, fault=1, cpu_rdata=0.
  - LH addr=0x403 with the macro undefined: behaves as addr=0x402.
- LW with no ack, TIMEOUT_CYCLES=8:
  - mem_req drops after 8 REQ cycles; DONE with cpu_rdata=0; fault=1 if the macro is defined.
- reset_n low during REQ:
  - mem_req=0 and cpu_stall=0 immediately.
  - A later ack is ignored; the next request starts cleanly.
